// File: rtl/sift_blur_pkg.sv
// Shared types for the blur scale scheduler: FSM encoding, error codes and
// the per-scale Gaussian kernel table (each row's weights sum to 2^shift).
package sift_blur_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_START,
    S_RUN,
    S_CHECK,
    S_DONE,
    S_ERR
  } state_t;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_TIMEOUT = 2'b01;
  localparam logic [1:0] ERR_COUNT   = 2'b10;

  localparam int KW = 8;

  typedef struct packed {
    logic [KW-1:0] w0;
    logic [KW-1:0] w1;
    logic [KW-1:0] w2;
    logic [KW-1:0] w3;
    logic [KW-1:0] w4;
    logic [3:0]    shift;
  } kernel_t;

  function automatic kernel_t kernel_lut(input logic [1:0] scale);
    kernel_t k;
    case (scale)
      2'd0:    k = {8'd1, 8'd4, 8'd6, 8'd4, 8'd1, 4'd4};
      2'd1:    k = {8'd2, 8'd4, 8'd4, 8'd4, 8'd2, 4'd4};
      2'd2:    k = {8'd3, 8'd3, 8'd4, 8'd3, 8'd3, 4'd4};
      default: k = {8'd1, 8'd2, 8'd2, 8'd2, 8'd1, 4'd3};
    endcase
    return k;
  endfunction

endpackage

// File: rtl/blur_scale_scheduler_if.sv
// Octave-control and blur-datapath signals of the scale scheduler.
// slave = scheduler side, master = octave control / datapath side.
interface blur_scale_scheduler_if #(
  parameter int CW = 8
);
  logic          start;
  logic          abort;
  logic          blur_valid;
  logic          blur_done;
  logic          blur_start;
  logic [CW-1:0] coef_w0;
  logic [CW-1:0] coef_w1;
  logic [CW-1:0] coef_w2;
  logic [CW-1:0] coef_w3;
  logic [CW-1:0] coef_w4;
  logic [3:0]    coef_shift;
  logic [1:0]    scale_idx;
  logic          scale_done;
  logic          octave_done;
  logic          busy;
  logic          error;
  logic [1:0]    err_code;

  modport slave (
    input  start, abort, blur_valid, blur_done,
    output blur_start, coef_w0, coef_w1, coef_w2, coef_w3, coef_w4, coef_shift,
           scale_idx, scale_done, octave_done, busy, error, err_code
  );

  modport master (
    output start, abort, blur_valid, blur_done,
    input  blur_start, coef_w0, coef_w1, coef_w2, coef_w3, coef_w4, coef_shift,
           scale_idx, scale_done, octave_done, busy, error, err_code
  );
endinterface

// File: rtl/blur_watchdog.sv
// Cycle watchdog: counts enabled cycles since clear; expired_o is high on the
// enabled cycle whose increment would reach the loaded terminal count.
module blur_watchdog #(
  parameter int W = 20
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         clr_i,
  input  logic         en_i,
  output logic         expired_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] lim_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      lim_q <= '0;
    end else begin
      if (load_i) lim_q <= load_val_i;
      if (clr_i) cnt_q <= '0;
      else if (en_i) cnt_q <= cnt_q + W'(1);
    end
  end

  assign expired_o = en_i && ((cnt_q + W'(1)) == lim_q);

endmodule

// File: rtl/blur_scale_scheduler.sv
// Steps the blur datapath through NUM_SCALES kernels per octave; first
// blur_start two cycles after start, all outputs registered, no backpressure.
module blur_scale_scheduler
  import sift_blur_pkg::*;
#(
  parameter int          WIDTH      = 128,
  parameter int          HEIGHT     = 128,
  parameter int          NUM_SCALES = 4,
  parameter logic [19:0] TIMEOUT    = 20'd100000,
  parameter int          CW         = 8
) (
  input logic                   clk,
  input logic                   rst_n,
  blur_scale_scheduler_if.slave bus
);

  localparam int             FRAME      = WIDTH * HEIGHT;
  localparam int             PW         = $clog2(FRAME + 1);
  localparam logic [PW-1:0]  PIX_TARGET = PW'(FRAME);
  localparam logic [PW-1:0]  PIX_MAX    = '1;
  localparam logic [1:0]     LAST_SCALE = 2'(NUM_SCALES - 1);

  state_t        state_q, state_d;
  logic [1:0]    scale_q, scale_d;
  logic [PW-1:0] pix_q, pix_d;
  kernel_t       coef_q, coef_d;
  logic          err_q, err_d;
  logic [1:0]    code_q, code_d;
  logic          scale_done_q, scale_done_d;
  logic          blur_start_q, busy_q, octave_done_q;
  logic          wd_load, wd_clr, wd_en, wd_expired;

  blur_watchdog #(.W(20)) u_watchdog (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (wd_load),
    .load_val_i (TIMEOUT - 20'd1),
    .clr_i      (wd_clr),
    .en_i       (wd_en),
    .expired_o  (wd_expired)
  );

  always_comb begin
    state_d      = state_q;
    scale_d      = scale_q;
    pix_d        = pix_q;
    coef_d       = coef_q;
    err_d        = err_q;
    code_d       = code_q;
    scale_done_d = 1'b0;
    wd_load      = 1'b0;
    wd_clr       = 1'b0;
    wd_en        = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d = S_LOAD;
          scale_d = 2'd0;
          err_d   = 1'b0;
          code_d  = ERR_NONE;
          wd_load = 1'b1;
        end
      end
      S_LOAD: begin
        coef_d  = kernel_lut(scale_q);
        state_d = S_START;
      end
      S_START: begin
        pix_d   = '0;
        wd_clr  = 1'b1;
        state_d = S_RUN;
      end
      S_RUN: begin
        wd_en = 1'b1;
        // Saturate so surplus pixels can never wrap back onto the target.
        if (bus.blur_valid && (pix_q != PIX_MAX)) pix_d = pix_q + PW'(1);
        if (bus.blur_done) begin
          state_d = S_CHECK;
        end else if (wd_expired) begin
          state_d = S_ERR;
          err_d   = 1'b1;
          code_d  = ERR_TIMEOUT;
        end
      end
      S_CHECK: begin
        if (pix_q == PIX_TARGET) begin
          scale_done_d = 1'b1;
          if (scale_q == LAST_SCALE) begin
            state_d = S_DONE;
          end else begin
            scale_d = scale_q + 2'd1;
            state_d = S_LOAD;
          end
        end else begin
          state_d = S_ERR;
          err_d   = 1'b1;
          code_d  = ERR_COUNT;
        end
      end
      S_DONE:  state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Abort overrides whatever the current state decided.
    if (bus.abort && (state_q != S_IDLE)) begin
      state_d      = S_IDLE;
      scale_d      = scale_q;
      pix_d        = pix_q;
      coef_d       = coef_q;
      err_d        = err_q;
      code_d       = code_q;
      scale_done_d = 1'b0;
      wd_clr       = 1'b0;
      wd_en        = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      scale_q       <= '0;
      pix_q         <= '0;
      coef_q        <= '0;
      err_q         <= 1'b0;
      code_q        <= ERR_NONE;
      scale_done_q  <= 1'b0;
      blur_start_q  <= 1'b0;
      busy_q        <= 1'b0;
      octave_done_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      scale_q       <= scale_d;
      pix_q         <= pix_d;
      coef_q        <= coef_d;
      err_q         <= err_d;
      code_q        <= code_d;
      scale_done_q  <= scale_done_d;
      blur_start_q  <= (state_d == S_START);
      busy_q        <= (state_d != S_IDLE);
      octave_done_q <= (state_d == S_DONE);
    end
  end

  assign bus.blur_start  = blur_start_q;
  assign bus.coef_w0     = CW'(coef_q.w0);
  assign bus.coef_w1     = CW'(coef_q.w1);
  assign bus.coef_w2     = CW'(coef_q.w2);
  assign bus.coef_w3     = CW'(coef_q.w3);
  assign bus.coef_w4     = CW'(coef_q.w4);
  assign bus.coef_shift  = coef_q.shift;
  assign bus.scale_idx   = scale_q;
  assign bus.scale_done  = scale_done_q;
  assign bus.octave_done = octave_done_q;
  assign bus.busy        = busy_q;
  assign bus.error       = err_q;
  assign bus.err_code    = code_q;

endmodule
